lvdc_acc_capture: RTL

LVDC_ACC_CAPTURE -- requirements
Module: lvdc_acc_capture

---
 rtl/lvdc_acc_capture.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/lvdc_acc_capture.sv
// LVDC accumulator serial capture: synchronizes WDA/PBV/AI3V, frames 26-bit words, buffers them in a FWFT FIFO.
// Optional inter-edge watchdog enabled by defining LVDC_CAPTURE_TIMEOUT_EN.
module lvdc_acc_capture #(
    parameter int FIFO_DEPTH     = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WDA,
    input  logic        PBV,
    input  logic        AI3V,
    output logic [25:0] WORD,
    output logic        WORD_VALID,
    input  logic        WORD_READY,
    output logic        OVERFLOW,
    input  logic        OVF_CLR,
    output logic        FRAME_ERR
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and WDA edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] wda_sync_q, pbv_sync_q, ai3v_sync_q;
    logic                   wda_prev_q;
    logic                   pbv_prev_q, pbv_prev_d;
    logic                   wda_s, pbv_s, ai3v_s;
    logic                   wda_edge, pbv_rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wda_sync_q  <= '0;
            pbv_sync_q  <= '0;
            ai3v_sync_q <= '0;
            wda_prev_q  <= 1'b0;
            pbv_prev_q  <= 1'b0;
        end else begin
            wda_sync_q  <= {wda_sync_q[SYNC_STAGES-2:0], WDA};
            pbv_sync_q  <= {pbv_sync_q[SYNC_STAGES-2:0], PBV};
            ai3v_sync_q <= {ai3v_sync_q[SYNC_STAGES-2:0], AI3V};
            wda_prev_q  <= wda_s;
            pbv_prev_q  <= pbv_prev_d;
        end
    end

    assign wda_s      = wda_sync_q[SYNC_STAGES-1];
    assign pbv_s      = pbv_sync_q[SYNC_STAGES-1];
    assign ai3v_s     = ai3v_sync_q[SYNC_STAGES-1];
    assign wda_edge   = wda_s & ~wda_prev_q;
    assign pbv_rise   = wda_edge & pbv_s & ~pbv_prev_q;
    assign pbv_prev_d = wda_edge ? pbv_s : pbv_prev_q;

    // ------------------------------------------------------------------
    // Optional inter-edge watchdog
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   timeout;

`ifdef LVDC_CAPTURE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;

    always_comb begin
        timer_d = '0;
        timeout = 1'b0;
        if (state_q != ST_IDLE && !wda_edge) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [4:0]  cnt_q, cnt_d;
    logic [25:0] shift_q, shift_d;
    logic [25:0] push_word;
    logic        push;
    logic        frame_err_q, frame_err_d;

    assign push_word = {shift_q[24:0], ai3v_s};

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pbv_rise) begin
                    state_d = ST_SYNC;
                    shift_d = '0;
                end
            end
            ST_SYNC: begin
                if (pbv_rise) begin
                    frame_err_d = 1'b1;
                end else if (wda_edge) begin
                    state_d = ST_DATA;
                    cnt_d   = 5'd26;
                end
            end
            ST_DATA: begin
                // A new frame strobe beats completion of the current word.
                if (pbv_rise) begin
                    state_d     = ST_SYNC;
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    shift_d     = '0;
                end else if (wda_edge) begin
                    shift_d = push_word;
                    cnt_d   = cnt_q - 5'd1;
                    if (cnt_q == 5'd1) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                        shift_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (timeout) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            cnt_d       = '0;
            shift_d     = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign FRAME_ERR = frame_err_q;

    // ------------------------------------------------------------------
    // First-word-fall-through FIFO and overflow flag
    // ------------------------------------------------------------------
    logic [25:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          fifo_full, pop, push_ok, ovf_evt;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign WORD_VALID = (count_q != '0);
    assign pop        = WORD_VALID & WORD_READY;
    assign push_ok    = push & (~fifo_full | pop);
    assign ovf_evt    = push & fifo_full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
        if (ovf_evt)      overflow_d = 1'b1;
        else if (OVF_CLR) overflow_d = 1'b0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is left unreset; the empty count gates WORD, so stale entries are never visible.
    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_word;
    end

    assign WORD     = WORD_VALID ? mem_q[rd_ptr_q] : '0;
    assign OVERFLOW = overflow_q;

endmodule
